// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : draw_sequencer
// Purpose  : Frame-level drawing controller. On a start request it runs the
//            screen filler to completion, then the Reuleaux shape drawer,
//            using a start/done handshake for each. It routes the active
//            producer's pixel stream to the VGA adapter plot port, clips
//            pixels outside the SCREEN_W x SCREEN_H frame, and counts
//            forwarded and clipped pixels.
// Ports    :
//   clk, rst_n                   clock, asynchronous active-low reset
//   start / done                 frame request / frame complete (held until
//                                start deasserts)
//   fill_start / fill_done       handshake with the screen filler
//   fill_x/y/colour/plot         filler pixel stream
//   shape_start / shape_done     handshake with the shape drawer
//   shape_x/y/colour/plot        drawer pixel stream (may be off-screen)
//   vga_x/y/colour/plot          registered pixel stream to the adapter
//   plotted_cnt / clipped_cnt    saturating per-frame pixel counters
// Revision : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic             fill_start,
  input  logic             fill_done,
  input  logic [7:0]       fill_x,
  input  logic [7:0]       fill_y,
  input  logic [2:0]       fill_colour,
  input  logic             fill_plot,
  output logic             shape_start,
  input  logic             shape_done,
  input  logic [7:0]       shape_x,
  input  logic [7:0]       shape_y,
  input  logic [2:0]       shape_colour,
  input  logic             shape_plot,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic [CNT_W-1:0] plotted_cnt,
  output logic [CNT_W-1:0] clipped_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_FILL_REL  = 3'd2,
    S_SHAPE     = 3'd3,
    S_SHAPE_REL = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Coordinates are compared at 9 bits so any 8-bit value fits below the limit.
  localparam logic [8:0] C_W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] C_H_LIM = 9'(SCREEN_H);

  state_t           state_q, state_d;
  logic             done_q, fill_start_q, shape_start_q;
  logic [7:0]       vga_x_q, vga_x_d;
  logic [6:0]       vga_y_q, vga_y_d;
  logic [2:0]       vga_colour_q, vga_colour_d;
  logic             vga_plot_q, vga_plot_d;
  logic [CNT_W-1:0] plotted_q, plotted_d;
  logic [CNT_W-1:0] clipped_q, clipped_d;

  logic             w_src_plot;
  logic [7:0]       w_src_x;
  logic [7:0]       w_src_y;
  logic [2:0]       w_src_colour;
  logic             w_onscreen;
  logic             w_fwd;
  logic             w_clip;
  logic             w_clear;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start)       state_d = S_FILL;
      S_FILL:      if (fill_done)   state_d = S_FILL_REL;
      S_FILL_REL:  if (!fill_done)  state_d = S_SHAPE;
      S_SHAPE:     if (shape_done)  state_d = S_SHAPE_REL;
      S_SHAPE_REL: if (!shape_done) state_d = S_DONE;
      S_DONE:      if (!start)      state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Active-source mux. The release states still belong to their producer so
  // that a pixel issued together with done is not lost.
  // --------------------------------------------------------------------------
  always_comb begin
    w_src_plot   = 1'b0;
    w_src_x      = 8'd0;
    w_src_y      = 8'd0;
    w_src_colour = 3'd0;
    case (state_q)
      S_FILL, S_FILL_REL: begin
        w_src_plot   = fill_plot;
        w_src_x      = fill_x;
        w_src_y      = fill_y;
        w_src_colour = fill_colour;
      end
      S_SHAPE, S_SHAPE_REL: begin
        w_src_plot   = shape_plot;
        w_src_x      = shape_x;
        w_src_y      = shape_y;
        w_src_colour = shape_colour;
      end
      default: ;
    endcase
  end

  assign w_onscreen = ({1'b0, w_src_x} < C_W_LIM) && ({1'b0, w_src_y} < C_H_LIM);
  assign w_fwd      = w_src_plot &  w_onscreen;
  assign w_clip     = w_src_plot & ~w_onscreen;
  assign w_clear    = (state_q == S_IDLE) && start;

  // --------------------------------------------------------------------------
  // Pixel path and counters (next values)
  // --------------------------------------------------------------------------
  always_comb begin
    vga_plot_d   = w_fwd;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (w_fwd) begin
      vga_x_d      = w_src_x;
      vga_y_d      = w_src_y[6:0];
      vga_colour_d = w_src_colour;
    end

    plotted_d = plotted_q;
    clipped_d = clipped_q;
    if (w_clear) begin
      plotted_d = '0;
      clipped_d = '0;
    end else begin
      if (w_fwd && (plotted_q != {CNT_W{1'b1}}))
        plotted_d = plotted_q + 1'b1;
      if (w_clip && (clipped_q != {CNT_W{1'b1}}))
        clipped_d = clipped_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers. Handshake outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      done_q        <= 1'b0;
      fill_start_q  <= 1'b0;
      shape_start_q <= 1'b0;
      vga_plot_q    <= 1'b0;
      vga_x_q       <= 8'd0;
      vga_y_q       <= 7'd0;
      vga_colour_q  <= 3'd0;
      plotted_q     <= '0;
      clipped_q     <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= (state_d == S_DONE);
      fill_start_q  <= (state_d == S_FILL);
      shape_start_q <= (state_d == S_SHAPE);
      vga_plot_q    <= vga_plot_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      plotted_q     <= plotted_d;
      clipped_q     <= clipped_d;
    end
  end

  assign done        = done_q;
  assign fill_start  = fill_start_q;
  assign shape_start = shape_start_q;
  assign vga_plot    = vga_plot_q;
  assign vga_x       = vga_x_q;
  assign vga_y       = vga_y_q;
  assign vga_colour  = vga_colour_q;
  assign plotted_cnt = plotted_q;
  assign clipped_cnt = clipped_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sequencer
// Purpose  : Self-checking bench for draw_sequencer: directed handshake,
//            latency, isolation and reset steps, then a full frame driven by
//            behavioural producers with a randomised drawer pixel list and a
//            reference frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_sequencer;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int CW = 16;
  localparam int NSHAPE = 300;
  localparam int NOFF   = 40;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          done, fill_start, shape_start;
  logic          fill_done, fill_plot, shape_done, shape_plot;
  logic [7:0]    fill_x, fill_y, shape_x, shape_y;
  logic [2:0]    fill_colour, shape_colour;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic [CW-1:0] plotted_cnt, clipped_cnt;

  draw_sequencer #(.SCREEN_W(W), .SCREEN_H(H), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .fill_start(fill_start), .fill_done(fill_done),
    .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
    .shape_start(shape_start), .shape_done(shape_done),
    .shape_x(shape_x), .shape_y(shape_y), .shape_colour(shape_colour), .shape_plot(shape_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .plotted_cnt(plotted_cnt), .clipped_cnt(clipped_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame buffer observed on the adapter port, and the reference picture.
  logic [3:0] fb   [0:W*H-1];
  logic [3:0] refb [0:W*H-1];
  int  bad_coord = 0;
  bit  overlap   = 1'b0;

  always @(negedge clk) begin
    if (vga_plot === 1'b1) begin
      if (vga_x < W && vga_y < H) fb[vga_y*W + vga_x] = {1'b0, vga_colour};
      else bad_coord++;
    end
    if (fill_start === 1'b1 && shape_start === 1'b1) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits (bounded) for fill_start(0) / shape_start(1) / done(2) to reach val.
  task automatic wait_sig(input int which, input logic val, input string tag);
    int   n = 0;
    logic s;
    forever begin
      case (which)
        0:       s = fill_start;
        1:       s = shape_start;
        default: s = done;
      endcase
      if (s === val || n >= 50) break;
      tick();
      n++;
    end
    chk(tag, {31'd0, s}, {31'd0, val});
  endtask

  int dx [NSHAPE];
  int dy [NSHAPE];
  int dc [NSHAPE];
  int exp_plot, exp_clip, nmis, j, t;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    fill_done = 1'b0; fill_plot = 1'b0; fill_x = '0; fill_y = '0; fill_colour = '0;
    shape_done = 1'b0; shape_plot = 1'b0; shape_x = '0; shape_y = '0; shape_colour = '0;
    tick(); tick();

    // ---- reset state
    chk("rst_done", done, 0);
    chk("rst_fill_start", fill_start, 0);
    chk("rst_shape_start", shape_start, 0);
    chk("rst_vga_plot", vga_plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_vga_colour", vga_colour, 0);
    chk("rst_plotted", plotted_cnt, 0);
    chk("rst_clipped", clipped_cnt, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_fill_start", fill_start, 0);
    chk("idle_done", done, 0);

    // ---- directed frame: handshake, latency, clipping, isolation
    start = 1'b1; tick();
    chk("fill_start_rise", fill_start, 1);
    chk("shape_start_in_fill", shape_start, 0);
    fill_plot = 1'b1; fill_x = 8'd159; fill_y = 8'd119; fill_colour = 3'd7; tick();
    chk("lat_vga_plot", vga_plot, 1);
    chk("lat_vga_x", vga_x, 159);
    chk("lat_vga_y", vga_y, 119);
    chk("lat_vga_colour", vga_colour, 7);
    chk("lat_plotted", plotted_cnt, 1);
    chk("lat_clipped", clipped_cnt, 0);
    fill_x = 8'd160; fill_y = 8'd5; fill_colour = 3'd2; tick();
    chk("clipx_vga_plot", vga_plot, 0);
    chk("clipx_clipped", clipped_cnt, 1);
    chk("clipx_hold_x", vga_x, 159);
    chk("clipx_hold_colour", vga_colour, 7);
    fill_plot = 1'b0;
    shape_plot = 1'b1; shape_x = 8'd3; shape_y = 8'd3; shape_colour = 3'd1; tick();
    chk("iso_fill_vga_plot", vga_plot, 0);
    chk("iso_fill_plotted", plotted_cnt, 1);
    chk("iso_fill_clipped", clipped_cnt, 1);
    shape_plot = 1'b0;
    fill_done = 1'b1; tick();
    chk("fill_start_drop", fill_start, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("hold_shape_start", shape_start, 0);
    end
    fill_done = 1'b0; tick();
    chk("shape_start_rise", shape_start, 1);
    fill_plot = 1'b1; fill_x = 8'd1; fill_y = 8'd1; tick();
    chk("iso_shape_vga_plot", vga_plot, 0);
    chk("iso_shape_plotted", plotted_cnt, 1);
    fill_plot = 1'b0;
    shape_plot = 1'b1; shape_x = 8'd10; shape_y = 8'd200; shape_colour = 3'd5; tick();
    chk("clipy_vga_plot", vga_plot, 0);
    chk("clipy_clipped", clipped_cnt, 2);
    shape_x = 8'd20; shape_y = 8'd30; shape_done = 1'b1; tick();
    chk("donepix_vga_plot", vga_plot, 1);
    chk("donepix_vga_x", vga_x, 20);
    chk("donepix_vga_y", vga_y, 30);
    chk("donepix_colour", vga_colour, 5);
    chk("donepix_plotted", plotted_cnt, 2);
    chk("shape_start_drop", shape_start, 0);
    shape_plot = 1'b0; tick();
    chk("shape_rel_done", done, 0);
    shape_done = 1'b0; tick();
    chk("done_rise", done, 1);
    tick(); tick();
    chk("done_held", done, 1);
    start = 1'b0; tick();
    chk("done_drop", done, 0);
    chk("idle_plotted_hold", plotted_cnt, 2);
    chk("idle_clipped_hold", clipped_cnt, 2);

    // ---- start drop ignored mid-frame, then async reset in SHAPE
    start = 1'b1; tick();
    chk("restart_clears", plotted_cnt, 0);
    start = 1'b0; fill_done = 1'b1; tick();
    fill_done = 1'b0; tick();
    chk("start_drop_ignored", shape_start, 1);
    shape_plot = 1'b1; shape_x = 8'd50; shape_y = 8'd60; shape_colour = 3'd3; tick();
    chk("pre_rst_plot", vga_plot, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", done, 0);
    chk("arst_shape_start", shape_start, 0);
    chk("arst_vga_plot", vga_plot, 0);
    chk("arst_vga_x", vga_x, 0);
    chk("arst_vga_y", vga_y, 0);
    chk("arst_vga_colour", vga_colour, 0);
    chk("arst_plotted", plotted_cnt, 0);
    tick();
    shape_plot = 1'b0; rst_n = 1'b1; tick(); tick();
    chk("post_rst_idle_fill", fill_start, 0);
    chk("post_rst_idle_shape", shape_start, 0);
    chk("post_rst_vga_plot", vga_plot, 0);

    // ---- full frame with behavioural producers and reference picture
    for (int i = 0; i < NSHAPE; i++) begin
      dx[i] = int'($urandom_range(0, W-1));
      dy[i] = (i < NOFF) ? int'($urandom_range(H, 255)) : int'($urandom_range(0, H-1));
      dc[i] = int'($urandom_range(0, 7));
    end
    for (int i = NSHAPE-1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = dx[i]; dx[i] = dx[j]; dx[j] = t;
      t = dy[i]; dy[i] = dy[j]; dy[j] = t;
      t = dc[i]; dc[i] = dc[j]; dc[j] = t;
    end
    for (int p = 0; p < W*H; p++) begin
      fb[p]   = 4'hF;
      refb[p] = 4'((p % W) % 8);
    end
    exp_plot = W*H;
    exp_clip = 0;
    for (int i = 0; i < NSHAPE; i++) begin
      if (dx[i] < W && dy[i] < H) begin
        refb[dy[i]*W + dx[i]] = 4'(dc[i]);
        exp_plot++;
      end else begin
        exp_clip++;
      end
    end

    start = 1'b1; tick();
    wait_sig(0, 1'b1, "frame_fill_start");
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        fill_plot = 1'b1; fill_x = 8'(x); fill_y = 8'(y); fill_colour = 3'(x % 8);
        fill_done = (x == W-1 && y == H-1);
        tick();
      end
    end
    fill_plot = 1'b0;
    wait_sig(0, 1'b0, "frame_fill_start_drop");
    fill_done = 1'b0;
    wait_sig(1, 1'b1, "frame_shape_start");
    chk("frame_no_fill_with_shape", fill_start, 0);
    for (int i = 0; i < NSHAPE; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        shape_plot = 1'b0; tick();
      end
      shape_plot = 1'b1; shape_x = 8'(dx[i]); shape_y = 8'(dy[i]); shape_colour = 3'(dc[i]);
      shape_done = (i == NSHAPE-1);
      tick();
    end
    shape_plot = 1'b0;
    wait_sig(1, 1'b0, "frame_shape_start_drop");
    shape_done = 1'b0;
    wait_sig(2, 1'b1, "frame_done");
    chk("frame_plotted", plotted_cnt, exp_plot);
    chk("frame_plotted_total", plotted_cnt, 19460);
    chk("frame_clipped", clipped_cnt, exp_clip);
    chk("frame_clipped_total", clipped_cnt, 40);
    nmis = 0;
    for (int p = 0; p < W*H; p++) if (fb[p] !== refb[p]) nmis++;
    chk("frame_buffer_mismatches", nmis, 0);
    chk("frame_bad_coords", bad_coord, 0);
    chk("handshake_overlap", {31'd0, overlap}, 0);
    tick(); tick();
    chk("frame_done_held", done, 1);
    start = 1'b0; tick();
    chk("frame_done_drop", done, 0);
    chk("frame_plotted_hold", plotted_cnt, exp_plot);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
